// File: rtl/program_memory_loader.sv
// Program memory and boot loader. Receives a little-endian byte image
// (length, words, checksum), writes it into a word RAM while holding the
// core stalled, then serves zero-latency instruction reads in RUN.
module program_memory_loader #(
    parameter int WORD_WIDTH = 16,   // two bytes per word; image format assumes 16
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 1024
) (
    input  logic                  gclk,
    input  logic                  nReset,
    input  logic [ADDR_WIDTH-1:0] MemAddr,
    output logic [WORD_WIDTH-1:0] MemRead,
    output logic                  Stall,
    input  logic                  LoadStart,
    input  logic                  LoadValid,
    input  logic [7:0]            LoadByte,
    output logic                  LoadReady,
    output logic                  LoadDone,
    output logic                  LoadError
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [WORD_WIDTH:0] DEPTH_LIM = (WORD_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_A   = (ADDR_WIDTH+1)'(DEPTH);

    typedef enum logic [2:0] {
        LEN_LO, LEN_HI, DATA_LO, DATA_HI, CSUM_LO, CSUM_HI, RUN, ERROR
    } state_t;

    state_t                state, nextState;
    logic [7:0]            lowByte;
    logic [WORD_WIDTH-1:0] nWords;
    logic [PTR_W-1:0]      wrPtr;
    logic [PTR_W-1:0]      wrPtrInc;
    logic [WORD_WIDTH-1:0] sum;
    logic [WORD_WIDTH-1:0] word;
    logic                  accept;
    logic                  lastWord;

    logic [WORD_WIDTH-1:0] mem [DEPTH];

    // The high byte always arrives second, so the current word is formed
    // from the incoming byte and the byte latched the cycle before.
    assign word     = {LoadByte, lowByte};
    assign wrPtrInc = wrPtr + 1'b1;
    assign lastWord = (WORD_WIDTH'(wrPtrInc) == nWords);

    // State register
    always_ff @(posedge gclk or negedge nReset) begin
        if (!nReset) state <= LEN_LO;
        else         state <= nextState;
    end

    // Next-state logic and state-decoded handshake/status outputs
    always_comb begin
        nextState = state;
        LoadReady = (state != RUN) && (state != ERROR);
        Stall     = (state != RUN);
        LoadError = (state == ERROR);
        accept    = LoadValid && LoadReady;
        case (state)
            LEN_LO:  if (accept) nextState = LEN_HI;
            LEN_HI:  if (accept) begin
                         if ({1'b0, word} > DEPTH_LIM) nextState = ERROR;
                         else if (word == '0)          nextState = CSUM_LO;
                         else                          nextState = DATA_LO;
                     end
            DATA_LO: if (accept) nextState = DATA_HI;
            DATA_HI: if (accept) nextState = lastWord ? CSUM_LO : DATA_LO;
            CSUM_LO: if (accept) nextState = CSUM_HI;
            CSUM_HI: if (accept) nextState = (word == sum) ? RUN : ERROR;
            RUN:     if (LoadStart) nextState = LEN_LO;
            ERROR:   if (LoadStart) nextState = LEN_LO;
            default: nextState = LEN_LO;
        endcase
    end

    // Loader datapath: byte latch, length, write pointer, running checksum, done pulse
    always_ff @(posedge gclk or negedge nReset) begin
        if (!nReset) begin
            lowByte  <= '0;
            nWords   <= '0;
            wrPtr    <= '0;
            sum      <= '0;
            LoadDone <= 1'b0;
        end else begin
            LoadDone <= 1'b0;
            case (state)
                LEN_LO, DATA_LO, CSUM_LO: if (accept) lowByte <= LoadByte;
                LEN_HI: if (accept) begin
                    nWords <= word;
                    wrPtr  <= '0;
                    sum    <= '0;
                end
                DATA_HI: if (accept) begin
                    sum   <= sum + word;
                    wrPtr <= wrPtrInc;
                end
                CSUM_HI: if (accept && (word == sum)) LoadDone <= 1'b1;
                RUN, ERROR: if (LoadStart) begin
                    wrPtr <= '0;
                    sum   <= '0;
                end
                default: ;
            endcase
        end
    end

    // RAM write port; contents deliberately survive reset
    always_ff @(posedge gclk) begin
        if (state == DATA_HI && accept) mem[wrPtr[IDX_W-1:0]] <= word;
    end

    // Fetch port: out-of-range addresses and any non-RUN state read as NOP (0)
    always_comb begin
        MemRead = '0;
        if (state == RUN && ({1'b0, MemAddr} < DEPTH_A)) MemRead = mem[MemAddr[IDX_W-1:0]];
    end

endmodule

// File: tb/tb_program_memory_loader.sv
// Self-checking bench for program_memory_loader: a per-cycle vector table
// for the basic load/read sequence, then directed sequences for error,
// empty/oversize/full-depth images, bubbles and mid-load reset.
module tb_program_memory_loader;

    localparam int DEPTH = 1024;

    typedef logic [7:0] byteq_t [$];

    typedef struct {
        logic        v;
        logic [7:0]  b;
        logic        s;
        logic [15:0] addr;
        logic        stall;
        logic        ready;
        logic        done;
        logic        err;
        logic [15:0] rd;
    } vec_t;

    logic        gclk = 1'b0;
    logic        nReset = 1'b0;
    logic [15:0] MemAddr = '0;
    logic [15:0] MemRead;
    logic        Stall;
    logic        LoadStart = 1'b0;
    logic        LoadValid = 1'b0;
    logic [7:0]  LoadByte = '0;
    logic        LoadReady;
    logic        LoadDone;
    logic        LoadError;

    int checks = 0;
    int failures = 0;

    vec_t        tbl [14];
    logic [15:0] wexp [DEPTH];

    program_memory_loader #(.WORD_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(DEPTH)) dut (
        .gclk(gclk), .nReset(nReset), .MemAddr(MemAddr), .MemRead(MemRead), .Stall(Stall),
        .LoadStart(LoadStart), .LoadValid(LoadValid), .LoadByte(LoadByte),
        .LoadReady(LoadReady), .LoadDone(LoadDone), .LoadError(LoadError)
    );

    always #5 gclk = ~gclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic eS, input logic eR, input logic eD,
                         input logic eE, input logic [15:0] eRd);
        logic [19:0] act, exp;
        act = {Stall, LoadReady, LoadDone, LoadError, MemRead};
        exp = {eS, eR, eD, eE, eRd};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got stall=%b ready=%b done=%b err=%b rd=%h, want stall=%b ready=%b done=%b err=%b rd=%h",
                     name, Stall, LoadReady, LoadDone, LoadError, MemRead, eS, eR, eD, eE, eRd);
        end
    endtask

    // One clock: drive inputs, take the edge, settle, then drop the strobes.
    task automatic cyc(input logic v, input logic [7:0] b, input logic s);
        LoadValid = v;
        LoadByte  = b;
        LoadStart = s;
        @(posedge gclk);
        #1;
        LoadValid = 1'b0;
        LoadStart = 1'b0;
        LoadByte  = 8'hFF;
    endtask

    task automatic sendBytes(input byteq_t q, input bit bubbles);
        foreach (q[i]) begin
            if (bubbles) cyc(1'b0, 8'hEE, 1'b0);
            cyc(1'b1, q[i], 1'b0);
        end
    endtask

    initial begin
        byteq_t good1, bad1, q;
        logic [7:0]  last;
        logic [15:0] s;

        // Checksum 0x0368 = 0x1234 + 0x5678 + 0x9ABC mod 2^16
        good1 = {8'h03, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'h68, 8'h03};
        bad1  = {8'h03, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'h69, 8'h03};

        //           v     b      s     addr     stall ready done err  rd
        tbl[0]  = '{1'b1, 8'h03, 1'b0, 16'd0,    1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[1]  = '{1'b1, 8'h00, 1'b0, 16'd0,    1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[2]  = '{1'b1, 8'h34, 1'b0, 16'd0,    1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[3]  = '{1'b1, 8'h12, 1'b0, 16'd0,    1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[4]  = '{1'b1, 8'h78, 1'b0, 16'd0,    1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[5]  = '{1'b1, 8'h56, 1'b0, 16'd0,    1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[6]  = '{1'b1, 8'hBC, 1'b0, 16'd0,    1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[7]  = '{1'b1, 8'h9A, 1'b0, 16'd0,    1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[8]  = '{1'b1, 8'h68, 1'b0, 16'd0,    1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[9]  = '{1'b1, 8'h03, 1'b0, 16'd0,    1'b0, 1'b0, 1'b1, 1'b0, 16'h1234};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 16'd1,    1'b0, 1'b0, 1'b0, 1'b0, 16'h5678};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 16'd2,    1'b0, 1'b0, 1'b0, 1'b0, 16'h9ABC};
        tbl[12] = '{1'b1, 8'h00, 1'b0, 16'd1024, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[13] = '{1'b0, 8'h00, 1'b1, 16'd1,    1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};

        // Reset state
        #12;
        check("reset", 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        @(negedge gclk);
        nReset = 1'b1;
        @(posedge gclk);
        #1;

        // Basic load, reads, out-of-range read, LoadStart from RUN
        for (int i = 0; i < 14; i++) begin
            MemAddr = tbl[i].addr;
            cyc(tbl[i].v, tbl[i].b, tbl[i].s);
            check($sformatf("load1[%0d]", i), tbl[i].stall, tbl[i].ready, tbl[i].done,
                  tbl[i].err, tbl[i].rd);
        end

        // Bad checksum
        MemAddr = 16'd0;
        q = bad1;
        last = q.pop_back();
        sendBytes(q, 1'b0);
        check("csum_hi_wait", 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        cyc(1'b1, last, 1'b0);
        check("bad_csum", 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
        cyc(1'b1, 8'h00, 1'b0);
        check("error_holds", 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
        cyc(1'b0, 8'h00, 1'b1);
        check("error_restart", 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);

        // Empty image: RAM keeps earlier contents
        sendBytes({8'h00, 8'h00}, 1'b0);
        check("n0_to_csum", 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        sendBytes({8'h00, 8'h00}, 1'b0);
        check("n0_done", 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234);
        cyc(1'b0, 8'h00, 1'b0);
        check("done_one_cycle", 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234);

        // N = DEPTH+1 rejected right after the length
        cyc(1'b0, 8'h00, 1'b1);
        sendBytes({8'h01, 8'h04}, 1'b0);
        check("n_too_big", 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);

        // N = DEPTH: full RAM
        cyc(1'b0, 8'h00, 1'b1);
        q = {8'h00, 8'h04};
        s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wexp[i] = 16'(i * 37 + 5);
            q.push_back(wexp[i][7:0]);
            q.push_back(wexp[i][15:8]);
            s = s + wexp[i];
        end
        q.push_back(s[7:0]);
        q.push_back(s[15:8]);
        MemAddr = 16'd1023;
        sendBytes(q, 1'b0);
        check("full_done", 1'b0, 1'b0, 1'b1, 1'b0, wexp[1023]);
        MemAddr = 16'd1024;
        #1;
        check("addr_depth", 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        MemAddr = 16'hFFFF;
        #1;
        check("addr_max", 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        MemAddr = 16'd0;
        cyc(1'b0, 8'h00, 1'b0);
        check("full_word0", 1'b0, 1'b0, 1'b0, 1'b0, wexp[0]);

        // Bubbles between every byte
        cyc(1'b0, 8'h00, 1'b1);
        q = good1;
        last = q.pop_back();
        sendBytes(q, 1'b1);
        cyc(1'b0, 8'hEE, 1'b0);
        check("bubble_wait", 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        MemAddr = 16'd2;
        cyc(1'b1, last, 1'b0);
        check("bubble_done", 1'b0, 1'b0, 1'b1, 1'b0, 16'h9ABC);

        // Partial load with an ignored LoadStart, then reset, then full reload
        MemAddr = 16'd0;
        cyc(1'b0, 8'h00, 1'b1);
        sendBytes({8'h02, 8'h00, 8'hAA}, 1'b0);
        cyc(1'b1, 8'hAA, 1'b1);
        cyc(1'b1, 8'hBB, 1'b0);
        check("partial_load", 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        nReset = 1'b0;
        #1;
        check("async_reset", 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        @(negedge gclk);
        nReset = 1'b1;
        @(posedge gclk);
        #1;
        sendBytes(good1, 1'b0);
        check("reload_w0", 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234);
        MemAddr = 16'd1;
        #1;
        check("reload_w1", 1'b0, 1'b0, 1'b1, 1'b0, 16'h5678);
        MemAddr = 16'd3;
        #1;
        check("reload_w3_kept", 1'b0, 1'b0, 1'b1, 1'b0, wexp[3]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
